// File: rtl/vga_sync_gen_module.sv
// ============================================================================
// vga_sync_gen_module : free-running VGA raster timing (sync, coordinates,
// active-video flag, frame-start pulse); all outputs registered.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_sync_gen_module #(
   parameter int H_VIS    = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_VIS    = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic        CLK_40M,
   input  logic        RSTn,
   output logic        HSYNC_Sig,
   output logic        VSYNC_Sig,
   output logic        Ready_Sig,
   output logic [10:0] Column_Addr_Sig,
   output logic [9:0]  Row_Addr_Sig,
   output logic        Frame_Start_Sig
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS_END    = 11'(H_VIS);
   localparam logic [10:0] H_SYNC_START = 11'(H_VIS + H_FP);
   localparam logic [10:0] H_SYNC_END   = 11'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0]  V_VIS_END    = 10'(V_VIS);
   localparam logic [9:0]  V_SYNC_START = 10'(V_VIS + V_FP);
   localparam logic [9:0]  V_SYNC_END   = 10'(V_VIS + V_FP + V_SYNC);

   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;

   logic h_last;
   logic v_last;
   logic h_in_sync;
   logic v_in_sync;
   logic visible;

   always_comb begin
      h_last    = (h_cnt == H_LAST);
      v_last    = (v_cnt == V_LAST);
      h_in_sync = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
      v_in_sync = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
      visible   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
   end

   always_ff @(posedge CLK_40M or negedge RSTn) begin
      if (!RSTn) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_last ? '0 : h_cnt + 11'd1;
         if (h_last) begin
            v_cnt <= v_last ? '0 : v_cnt + 10'd1;
         end
      end
   end

   // Outputs decode the pre-increment count, so all of them lag the counters by one clock together.
   always_ff @(posedge CLK_40M or negedge RSTn) begin
      if (!RSTn) begin
         HSYNC_Sig       <= ~SYNC_POL;
         VSYNC_Sig       <= ~SYNC_POL;
         Ready_Sig       <= 1'b0;
         Column_Addr_Sig <= '0;
         Row_Addr_Sig    <= '0;
         Frame_Start_Sig <= 1'b0;
      end else begin
         HSYNC_Sig       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
         VSYNC_Sig       <= v_in_sync ? SYNC_POL : ~SYNC_POL;
         Ready_Sig       <= visible;
         Column_Addr_Sig <= visible ? h_cnt : '0;
         Row_Addr_Sig    <= visible ? v_cnt : '0;
         Frame_Start_Sig <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

endmodule

`default_nettype wire
